interp2x_stream_core: RTL and testbench

INTERP2X_STREAM_CORE -- requirements
Module: interp2x_stream_core

---
 rtl/interp_pkg.sv | 12 +
 rtl/interp_line_ram.sv | 23 ++
 rtl/interp2x_stream_core.sv | 142 ++++++++++++++
 tb/tb_interp2x_stream_core.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interp_pkg.sv
// rtl/interp_pkg.sv - shared defaults and output quadrant indices for the 2x interpolator
package interp_pkg;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_CHANNELS = 1;
    localparam int DEF_MAX_W    = 1024;

    // Quadrant slot within m_data, in units of one packed pixel
    localparam int Q00 = 0;
    localparam int Q01 = 1;
    localparam int Q10 = 2;
    localparam int Q11 = 3;
endpackage

// File: rtl/interp_line_ram.sv
// rtl/interp_line_ram.sv - single-port read-first line RAM holding the previous row by column
module interp_line_ram
    import interp_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_W,
    parameter int AW    = 10,
    parameter int W     = DEF_DATA_W
) (
    input  logic          sclk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge sclk) begin
        if (en) begin
            rdata     <= mem[addr];
            mem[addr] <= wdata;
        end
    end
endmodule

// File: rtl/interp2x_stream_core.sv
// rtl/interp2x_stream_core.sv - 2x bilinear upscaler: one input pixel in, one 2x2 block out
module interp2x_stream_core
    import interp_pkg::*;
#(
    parameter int  DATA_W   = DEF_DATA_W,
    parameter int  CHANNELS = DEF_CHANNELS,
    parameter int  MAX_W    = DEF_MAX_W,
    localparam int LW       = $clog2(MAX_W + 1),
    localparam int PW       = CHANNELS * DATA_W,
    localparam int AW       = (MAX_W > 1) ? $clog2(MAX_W) : 1
) (
    input  logic            sclk,
    input  logic            rst_n,
    input  logic [LW-1:0]   cfg_width,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [PW-1:0]   s_data,
    input  logic            s_sof,
    input  logic            s_eol,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [4*PW-1:0] m_data,
    output logic            m_sof,
    output logic            m_eol,
    output logic            err_width
);
    logic [1:0] rst_sync;
    logic       rst_int_n;

    // Assert immediately, release only after two clean sclk edges
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    logic          advance, accept, at_last;
    logic [LW-1:0] col, col_eff, width_lat, width_eff;
    logic [15:0]   row, row_eff;

    assign advance = !m_valid || m_ready;
    assign s_ready = rst_int_n && advance;
    assign accept  = s_valid && s_ready;

    always_comb begin
        col_eff   = s_sof ? '0 : col;
        row_eff   = s_sof ? '0 : row;
        width_eff = s_sof ? cfg_width : width_lat;
        at_last   = (col_eff == width_eff - LW'(1));
    end

    always_ff @(posedge sclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            col       <= '0;
            row       <= '0;
            width_lat <= LW'(MAX_W);
            err_width <= 1'b0;
        end else begin
            err_width <= 1'b0;
            if (accept) begin
                if (s_sof) width_lat <= cfg_width;
                err_width <= (s_eol != at_last);
                // A line ends on s_eol or on reaching the width, whichever comes first
                if (s_eol || at_last) begin
                    col <= '0;
                    row <= (&row_eff) ? row_eff : row_eff + 16'd1;
                end else begin
                    col <= col_eff + LW'(1);
                    row <= row_eff;
                end
            end
        end
    end

    logic [PW-1:0]   ram_rd, up_pix, s1_pix, left_pix, left_up;
    logic            s1_valid, s1_sof, s1_eol, s1_col0, s1_row0;
    logic [4*PW-1:0] blk;

    interp_line_ram #(.DEPTH(MAX_W), .AW(AW), .W(PW)) u_line_ram (
        .sclk  (sclk),
        .en    (accept),
        .addr  (col_eff[AW-1:0]),
        .wdata (s_data),
        .rdata (ram_rd)
    );

    assign up_pix = s1_row0 ? s1_pix : ram_rd;

    always_ff @(posedge sclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            s1_valid <= 1'b0;
            s1_pix   <= '0;
            s1_sof   <= 1'b0;
            s1_eol   <= 1'b0;
            s1_col0  <= 1'b0;
            s1_row0  <= 1'b0;
            left_pix <= '0;
            left_up  <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_sof    <= 1'b0;
            m_eol    <= 1'b0;
        end else if (advance) begin
            s1_valid <= accept;
            if (accept) begin
                s1_pix   <= s_data;
                s1_sof   <= s_sof;
                s1_eol   <= s_eol;
                s1_col0  <= (col_eff == '0);
                s1_row0  <= (row_eff == '0);
                // Stage 1 still holds the previous stream pixel: it becomes the left neighbour
                left_pix <= s1_pix;
                left_up  <= up_pix;
            end
            m_valid <= s1_valid;
            if (s1_valid) begin
                m_data <= blk;
                m_sof  <= s1_sof;
                m_eol  <= s1_eol;
            end
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [DATA_W-1:0] a, l, u, ul;
        logic [DATA_W:0]   sum_h, sum_v;
        logic [DATA_W+1:0] sum_4;

        assign a     = s1_pix[ch*DATA_W +: DATA_W];
        assign u     = up_pix[ch*DATA_W +: DATA_W];
        assign l     = s1_col0 ? a : left_pix[ch*DATA_W +: DATA_W];
        assign ul    = s1_col0 ? u : left_up[ch*DATA_W +: DATA_W];
        assign sum_h = {1'b0, l} + {1'b0, a} + (DATA_W+1)'(1);
        assign sum_v = {1'b0, u} + {1'b0, a} + (DATA_W+1)'(1);
        assign sum_4 = {2'b0, ul} + {2'b0, u} + {2'b0, l} + {2'b0, a} + (DATA_W+2)'(2);

        assign blk[Q11*PW + ch*DATA_W +: DATA_W] = a;
        assign blk[Q10*PW + ch*DATA_W +: DATA_W] = sum_h[DATA_W:1];
        assign blk[Q01*PW + ch*DATA_W +: DATA_W] = sum_v[DATA_W:1];
        assign blk[Q00*PW + ch*DATA_W +: DATA_W] = sum_4[DATA_W+1:2];
    end
endmodule

// File: tb/tb_interp2x_stream_core.sv
// tb/tb_interp2x_stream_core.sv - scoreboard bench for the 2x interpolator core
module tb_interp2x_stream_core;
    localparam int DW = 10;
    localparam int CH = 3;
    localparam int MW = 16;
    localparam int LW = $clog2(MW + 1);
    localparam int PW = DW * CH;
    localparam int OW = 4 * PW;

    logic          sclk = 1'b0;
    logic          rst_n = 1'b0;
    logic [LW-1:0] cfg_width = LW'(MW);
    logic          s_valid = 1'b0, s_sof = 1'b0, s_eol = 1'b0;
    logic          s_ready;
    logic [PW-1:0] s_data = '0;
    logic          m_valid, m_sof, m_eol, err_width;
    logic          m_ready = 1'b1;
    logic [OW-1:0] m_data;

    interp2x_stream_core #(.DATA_W(DW), .CHANNELS(CH), .MAX_W(MW)) dut (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .cfg_width (cfg_width),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_sof     (s_sof),
        .s_eol     (s_eol),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_sof     (m_sof),
        .m_eol     (m_eol),
        .err_width (err_width)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        logic [OW-1:0] data;
        logic          sof;
        logic          eol;
        int            cyc;
    } exp_t;

    exp_t          exp_q[$];
    logic [OW-1:0] got_q[$];
    int            vectors = 0, miscompares = 0, cyc = 0;
    int            err_seen = 0, err_exp = 0, rdy_mode = 0;
    bit            lat_chk = 1'b0;

    int            m_col = 0, m_row = 0, m_width = MW;
    logic [PW-1:0] colmem [MW];
    logic [PW-1:0] last_pix = '0, last_up = '0;

    always @(posedge sclk) cyc <= cyc + 1;

    task automatic check(string name, logic [127:0] got, logic [127:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    function automatic logic [PW-1:0] splat(int v);
        logic [PW-1:0] p;
        for (int c = 0; c < CH; c++) p[c*DW +: DW] = DW'(v);
        return p;
    endfunction

    function automatic logic [PW-1:0] rand_pix();
        logic [PW-1:0] p;
        for (int c = 0; c < CH; c++) p[c*DW +: DW] = DW'($urandom);
        return p;
    endfunction

    // Reference 2x2 block from the four neighbours, plain integer rounding
    function automatic logic [OW-1:0] ref_block(logic [PW-1:0] p, logic [PW-1:0] l,
                                                logic [PW-1:0] u, logic [PW-1:0] ul);
        logic [OW-1:0] r;
        int a, b, d, e;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            a = int'(p[c*DW +: DW]);
            b = int'(l[c*DW +: DW]);
            d = int'(u[c*DW +: DW]);
            e = int'(ul[c*DW +: DW]);
            r[3*PW + c*DW +: DW] = DW'(a);
            r[2*PW + c*DW +: DW] = DW'((b + a + 1) / 2);
            r[1*PW + c*DW +: DW] = DW'((d + a + 1) / 2);
            r[0*PW + c*DW +: DW] = DW'((e + d + b + a + 2) / 4);
        end
        return r;
    endfunction

    task automatic model_beat(logic [PW-1:0] pix, logic sof, logic eol, int acc);
        logic [PW-1:0] up, left, ul;
        exp_t e;
        bit last;
        if (sof) begin
            m_col = 0;
            m_row = 0;
            m_width = int'(cfg_width);
        end
        up   = (m_row == 0) ? pix : colmem[m_col];
        left = (m_col == 0) ? pix : last_pix;
        ul   = (m_col == 0) ? up : last_up;
        e.data = ref_block(pix, left, up, ul);
        e.sof  = sof;
        e.eol  = eol;
        e.cyc  = acc;
        exp_q.push_back(e);
        colmem[m_col] = pix;
        last_pix = pix;
        last_up  = up;
        last = (m_col == m_width - 1);
        if (eol != last) err_exp++;
        if (eol || last) begin
            m_col = 0;
            m_row++;
        end else begin
            m_col++;
        end
    endtask

    task automatic send(logic [PW-1:0] pix, logic sof, logic eol);
        int t = 0;
        int acc;
        s_valid = 1'b1;
        s_data  = pix;
        s_sof   = sof;
        s_eol   = eol;
        @(negedge sclk);
        while (!s_ready && t < 200) begin
            @(negedge sclk);
            t++;
        end
        acc = cyc;
        check("s_ready_wait", s_ready, 1);
        @(posedge sclk);
        if (s_ready) model_beat(pix, sof, eol, acc);
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge sclk);
            #1;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge sclk);
            t++;
        end
        check("drain_outstanding", exp_q.size(), 0);
        exp_q.delete();
        idle(3);
    endtask

    initial begin : ready_drv
        int ph = 0;
        forever begin
            @(posedge sclk);
            #1;
            case (rdy_mode)
                0: m_ready = 1'b1;
                1: begin
                    m_ready = (ph % 4 == 0) || (ph % 4 == 3);
                    ph++;
                end
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : monitor
        exp_t e;
        logic [OW+1:0] hold;
        bit stall_pend;
        stall_pend = 1'b0;
        hold = '0;
        forever begin
            @(negedge sclk);
            if (!rst_n) begin
                stall_pend = 1'b0;
            end else begin
                if (err_width) err_seen++;
                if (stall_pend) check("stall_hold", {m_valid, m_data, m_sof, m_eol}, {1'b1, hold});
                stall_pend = m_valid && !m_ready;
                hold = {m_data, m_sof, m_eol};
                if (m_valid && m_ready) begin
                    check("beat_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("m_data", m_data, e.data);
                        check("m_sof_eol", {m_sof, m_eol}, {e.sof, e.eol});
                        if (lat_chk) check("latency", cyc - e.cyc, 2);
                    end
                    got_q.push_back(m_data);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int vals [2][3];
        int n0, w, h;
        logic [PW-1:0] p;
        vals = '{'{10, 20, 30}, '{50, 60, 70}};

        idle(3);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_flags", {m_sof, m_eol}, 0);
        check("rst_err_width", err_width, 0);
        rst_n = 1'b1;
        idle(4);
        check("rst_s_ready", s_ready, 1);

        // 3x2 frame with known blocks and a latency check
        lat_chk = 1'b1;
        cfg_width = LW'(3);
        got_q.delete();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                send(splat(vals[r][c]), r == 0 && c == 0, c == 2);
        drain();
        lat_chk = 1'b0;
        check("frame3x2_count", got_q.size(), 6);
        if (got_q.size() >= 6) begin
            check("blk_r0c0", got_q[0], {4{splat(10)}});
            check("blk_r1c1", got_q[4], {splat(60), splat(55), splat(40), splat(35)});
        end

        // Rounding and full-scale frames, 2x2 each
        cfg_width = LW'(2);
        got_q.delete();
        send(splat(0), 1, 0); send(splat(0), 0, 1);
        send(splat(0), 0, 0); send(splat(1), 0, 1);
        for (int k = 0; k < 4; k++) send(splat(255), k == 0, k % 2 == 1);
        for (int k = 0; k < 4; k++) send(splat(1023), k == 0, k % 2 == 1);
        drain();
        check("round_count", got_q.size(), 12);
        if (got_q.size() >= 12) begin
            check("round_q10_q01", got_q[3][3*PW-1:PW], {splat(1), splat(1)});
            check("all_255", got_q[7], {4{splat(255)}});
            check("all_max", got_q[11], {4{splat(1023)}});
        end

        // Back-pressure 1,0,0,1 over two 16-pixel lines
        rdy_mode = 1;
        cfg_width = LW'(16);
        n0 = got_q.size();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 16; c++)
                send(rand_pix(), r == 0 && c == 0, c == 15);
        drain();
        check("bp_beats", got_q.size() - n0, 32);
        rdy_mode = 0;

        // Width errors: early s_eol, then a wrap without s_eol
        check("err_quiet", err_seen, 0);
        err_seen = 0;
        err_exp  = 0;
        cfg_width = LW'(4);
        for (int c = 0; c < 3; c++) send(rand_pix(), c == 0, c == 2);
        for (int c = 0; c < 4; c++) send(rand_pix(), 0, c == 3);
        for (int c = 0; c < 4; c++) send(rand_pix(), 0, 0);
        for (int c = 0; c < 4; c++) send(rand_pix(), 0, c == 3);
        drain();
        check("err_pulses", err_seen, 2);

        // Reset during row 2, then pre-sof beats and a fresh frame
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < ((r == 2) ? 2 : 4); c++)
                send(rand_pix(), r == 0 && c == 0, c == 3);
        rst_n = 1'b0;
        #1;
        check("reset_m_valid", m_valid, 0);
        exp_q.delete();
        m_col = 0; m_row = 0; m_width = MW;
        idle(2);
        rst_n = 1'b1;
        idle(4);
        check("release_s_ready", s_ready, 1);
        n0 = got_q.size();
        p = rand_pix();
        send(p, 0, 0);
        send(rand_pix(), 0, 0);
        send(rand_pix(), 0, 0);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++)
                send(rand_pix(), r == 0 && c == 0, c == 3);
        drain();
        check("post_reset_count", got_q.size() - n0, 11);
        if (got_q.size() > n0) check("post_reset_r0c0", got_q[n0], {4{p}});

        // Random 8x4 frame and random frames under random stalls and gaps
        rdy_mode = 2;
        cfg_width = LW'(8);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++) begin
                send(rand_pix(), r == 0 && c == 0, c == 7);
                idle($urandom_range(0, 2));
            end
        for (int f = 0; f < 3; f++) begin
            w = $urandom_range(1, MW);
            h = $urandom_range(1, 3);
            cfg_width = LW'(w);
            for (int r = 0; r < h; r++)
                for (int c = 0; c < w; c++) begin
                    send(rand_pix(), r == 0 && c == 0, c == w - 1);
                    idle($urandom_range(0, 1));
                end
        end
        drain();
        check("err_total", err_seen, err_exp);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
